matmul_wb_scheduler: RTL

- Sequences the 2x2 matrix-multiply unit and schedules its four 8-bit results onto the single register-file write port.
- The normal pipeline writeback keeps priority on that port.
- Sits between decode (issue), the matrix multiplier (start/done/C) and the register file write port; replaces ad-hoc write-port muxing.
- Generates the pipeline stall for the whole matrix operation.

---
 rtl/matmul_wb_scheduler_pkg.sv | 22 ++
 rtl/matmul_wb_scheduler_wb_port_arbiter.sv | 37 +++
 rtl/matmul_wb_scheduler.sv | 136 +++++++++++++
 3 files changed

// File: rtl/matmul_wb_scheduler_pkg.sv
// Shared types and defaults for the matrix-multiply writeback scheduler.
package matmul_wb_scheduler_pkg;

  localparam int unsigned DataW = 8;
  localparam int unsigned AddrW = 3;
  localparam int unsigned NElem = 4;
  localparam int unsigned IdxW  = $clog2(NElem);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait,
    StDrain
  } mm_state_e;

  // Pick element idx out of the packed result; element i lives at bits [8i+7:8i].
  function automatic logic [DataW-1:0] get_elem(input logic [NElem*DataW-1:0] c,
                                                input logic [IdxW-1:0]        idx);
    return c[idx*DataW +: DataW];
  endfunction

endpackage

// File: rtl/matmul_wb_scheduler_wb_port_arbiter.sv
// Fixed-priority mux for the single register-file write port.
// The normal pipeline writeback always wins; the matrix drain only gets free slots.
module matmul_wb_scheduler_wb_port_arbiter #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 8
) (
  input  logic              wb_write,
  input  logic [ADDR_W-1:0] wb_destreg,
  input  logic [DATA_W-1:0] wb_wrtdata,
  input  logic              mm_req,
  input  logic [ADDR_W-1:0] mm_destreg,
  input  logic [DATA_W-1:0] mm_wrtdata,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_destreg,
  output logic [DATA_W-1:0] rf_wrtdata,
  output logic              mm_grant
);

  // Select the write-port source and strobe the grant when the matrix element goes out.
  always_comb begin
    rf_write   = 1'b0;
    rf_destreg = '0;
    rf_wrtdata = '0;
    mm_grant   = 1'b0;
    if (wb_write) begin
      rf_write   = 1'b1;
      rf_destreg = wb_destreg;
      rf_wrtdata = wb_wrtdata;
    end else if (mm_req) begin
      rf_write   = 1'b1;
      rf_destreg = mm_destreg;
      rf_wrtdata = mm_wrtdata;
      mm_grant   = 1'b1;
    end
  end

endmodule

// File: rtl/matmul_wb_scheduler.sv
// Sequences the 2x2 matrix multiplier and drains its four results through the
// shared register-file write port, stalling IF/ID for the whole operation.
module matmul_wb_scheduler
  import matmul_wb_scheduler_pkg::*;
#(
  parameter int unsigned DATA_W  = DataW,
  parameter int unsigned ADDR_W  = AddrW,
  parameter int unsigned N_ELEM  = NElem,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mm_issue,
  input  logic [ADDR_W-1:0]        mm_dest_base,
  output logic                     mm_start,
  input  logic                     mm_done,
  input  logic [N_ELEM*DATA_W-1:0] mm_C,
  input  logic                     wb_write,
  input  logic [ADDR_W-1:0]        wb_destreg,
  input  logic [DATA_W-1:0]        wb_wrtdata,
  output logic                     rf_write,
  output logic [ADDR_W-1:0]        rf_destreg,
  output logic [DATA_W-1:0]        rf_wrtdata,
  output logic                     stall,
  output logic                     busy,
  output logic                     issue_drop,
  output logic                     timeout_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  mm_state_e                 state_q, state_d;
  logic [IdxW-1:0]           idx_q, idx_d;
  logic [N_ELEM*DATA_W-1:0]  c_q, c_d;
  logic [ADDR_W-1:0]         base_q, base_d;
  logic [CntW-1:0]           cnt_q, cnt_d;

  logic                      mm_req;
  logic                      mm_grant;
  logic [ADDR_W-1:0]         mm_destreg;
  logic [DATA_W-1:0]         mm_wrtdata;

  // State, drain index, latched result, base register and timeout counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      c_q     <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic plus the start and timeout pulses.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    c_d         = c_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    mm_start    = 1'b0;
    timeout_err = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mm_issue) begin
          base_d  = mm_dest_base;
          state_d = StStart;
        end
      end
      StStart: begin
        mm_start = 1'b1;
        cnt_d    = '0;
        state_d  = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        // Done takes precedence over a timeout landing in the same cycle.
        if (mm_done) begin
          c_d     = mm_C;
          idx_d   = '0;
          state_d = StDrain;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          timeout_err = 1'b1;
          state_d     = StIdle;
        end
      end
      StDrain: begin
        // Index only moves when the port was actually granted; a blocked slot is retried.
        if (mm_grant) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == IdxW'(N_ELEM - 1)) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Status outputs; stall covers the issue cycle itself so decode freezes immediately.
  always_comb begin
    busy       = (state_q != StIdle);
    stall      = busy | mm_issue;
    issue_drop = busy & mm_issue;
  end

  // Matrix-side write request for the arbiter, addressed modulo the register count.
  always_comb begin
    mm_req     = (state_q == StDrain);
    mm_destreg = base_q + ADDR_W'(idx_q);
    mm_wrtdata = get_elem(c_q, idx_q);
  end

  matmul_wb_scheduler_wb_port_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_arbiter (
    .wb_write   (wb_write),
    .wb_destreg (wb_destreg),
    .wb_wrtdata (wb_wrtdata),
    .mm_req     (mm_req),
    .mm_destreg (mm_destreg),
    .mm_wrtdata (mm_wrtdata),
    .rf_write   (rf_write),
    .rf_destreg (rf_destreg),
    .rf_wrtdata (rf_wrtdata),
    .mm_grant   (mm_grant)
  );

endmodule
